// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-look-ahead adder/subtractor with valid/ready handshake.
// Optional output saturation is enabled with the CLA_SAT_EN macro (adds port sat).
module cla_addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
`ifdef CLA_SAT_EN
    input  logic             sat,
`endif
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG   = WIDTH / GROUP;
    localparam int N    = (NG + STAGES - 1) / STAGES;
    localparam int L    = STAGES - 1;
    localparam int MIDN = (STAGES > 1) ? STAGES - 1 : 1;

    // c: carry into the lowest unresolved group; cmsb: carry into the MSB bit
    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cmsb;
        logic             sat;
    } beat_t;

    function automatic logic [GROUP-1:0] grp_carries(input logic [GROUP-1:0] p,
                                                     input logic [GROUP-1:0] g,
                                                     input logic             ci);
        logic [GROUP-1:0] c;
        logic             t;
        c = '0;
        for (int i = 0; i < GROUP; i++) begin
            t = ci;
            for (int k = 0; k < i; k++) t = t & p[k];
            c[i] = t;
            for (int k = 0; k < i; k++) begin
                t = g[k];
                for (int m = k + 1; m < i; m++) t = t & p[m];
                c[i] = c[i] | t;
            end
        end
        return c;
    endfunction

    function automatic logic [1:0] grp_gp(input logic [GROUP-1:0] p,
                                          input logic [GROUP-1:0] g);
        logic gg;
        logic t;
        gg = 1'b0;
        for (int k = 0; k < GROUP; k++) begin
            t = g[k];
            for (int m = k + 1; m < GROUP; m++) t = t & p[m];
            gg = gg | t;
        end
        return {gg, &p};
    endfunction

    function automatic beat_t resolve(input beat_t bi, input int lo, input int hi);
        beat_t            bo;
        logic [GROUP-1:0] cc;
        logic [1:0]       gp;
        bo = bi;
        for (int j = 0; j < NG; j++) begin
            if (j >= lo && j < hi) begin
                cc = grp_carries(bi.p[j*GROUP +: GROUP], bi.g[j*GROUP +: GROUP], bo.c);
                gp = grp_gp(bi.p[j*GROUP +: GROUP], bi.g[j*GROUP +: GROUP]);
                bo.s[j*GROUP +: GROUP] = bi.p[j*GROUP +: GROUP] ^ cc;
                if (j == NG - 1) bo.cmsb = cc[GROUP-1];
                bo.c = gp[1] | (gp[0] & bo.c);
            end
        end
        return bo;
    endfunction

    beat_t            in_beat;
    beat_t            stage_d [STAGES];
    beat_t            stage_q [MIDN];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0] r_d, r_q;
    logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;
    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff        = sub ? ~b : b;
        in_beat      = '0;
        in_beat.p    = a ^ b_eff;
        in_beat.g    = a & b_eff;
        in_beat.c    = cin ^ sub;
`ifdef CLA_SAT_EN
        in_beat.sat  = sat;
`else
        in_beat.sat  = 1'b0;
`endif
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        beat_t src;
        if (s == 0) begin : g_first
            assign src = in_beat;
        end else begin : g_mid
            assign src = stage_q[s-1];
        end
        assign stage_d[s] = resolve(src, s * N, (s + 1) * N);
    end

    // A stage empties when its beat can move on; only then may it take a new one
    always_comb begin
        adv    = '0;
        adv[L] = valid_q[L] & out_ready;
        for (int s = L - 1; s >= 0; s--)
            adv[s] = valid_q[s] & (~valid_q[s+1] | adv[s+1]);
    end

    assign in_ready = ~reset & (~valid_q[0] | adv[0]);

    always_comb begin
        load    = '0;
        load[0] = in_valid & in_ready;
        for (int s = 1; s < STAGES; s++) load[s] = adv[s-1];
    end

    // Sign of an overflowed result equals the shared sign of both effective operands
    always_comb begin
        cout_d = stage_d[L].c;
        ovf_d  = stage_d[L].cmsb ^ stage_d[L].c;
        r_d    = stage_d[L].s;
        if (stage_d[L].sat && ovf_d)
            r_d = stage_d[L].g[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        zero_d = (r_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int s = 0; s < MIDN; s++) stage_q[s] <= '0;
            r_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (load[s])     valid_q[s] <= 1'b1;
                else if (adv[s]) valid_q[s] <= 1'b0;
            end
            for (int s = 0; s < L; s++)
                if (load[s]) stage_q[s] <= stage_d[s];
            if (load[L]) begin
                r_q    <= r_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = valid_q[L];
    assign r         = r_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
Parametrised, pipelined carry-look-ahead adder/subtractor for the ALU datapath. Generalises the fixed-width 7-bit CLA adder to WIDTH bits, built from GROUP-bit look-ahead groups whose group carries ripple across STAGES register stages. It adds subtract mode, carry/overflow/zero flags and an elastic valid/ready pipeline at full throughput.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of GROUP.
GROUP, 4, bits per look-ahead group; full CLA inside each group.
STAGES, 2, register stages (latency); 1 <= STAGES <= WIDTH/GROUP.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat offered
in_ready  output  1  pipeline can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B+cin; 1 = A+~B+(~cin), i.e. A-B-cin
cin  input  1  carry in (add) / borrow in (sub)
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
r  output  WIDTH  result
cout  output  1  carry out of MSB (sub: 1 = no borrow)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
zero  output  1  r == 0

Behaviour:
- One clock, synchronous active-high reset; all flops update on rising clk only.
- Reset: every stage valid bit cleared; r, cout, ovf, zero = 0; out_valid = 0. in_ready = 0 while reset is high, 1 the cycle after.
- Operand prep at accept: b_eff = sub ? ~b : b; c_eff = cin XOR sub.
- Per group: p = a^b_eff, g = a&b_eff; in-group carries by full look-ahead (no ripple inside a group); group G/P computed.
- Groups split over stages: stage k resolves groups [k*N, (k+1)*N), where N = ceil((WIDTH/GROUP)/STAGES). The last stage takes the remainder. The group carry-in is registered between stages. Unresolved upper-group p/g and resolved lower sum bits travel with the beat.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+STAGES-1, i.e. STAGES cycles.
- Handshake: a beat transfers on in_valid & in_ready, and leaves on out_valid & out_ready. Each stage holds at most one beat and advances when the next stage is empty or advancing. in_ready = !stage0_valid | stage0_advances (combinational from out_ready).
- Throughput: 1 beat/cycle with out_ready held high. Up to STAGES beats are buffered when out_ready is low. Order is preserved; no beat is dropped or duplicated.
- Outputs r/cout/ovf/zero are registered and stable while out_valid & !out_ready. They hold their last value when out_valid = 0.
- Simultaneous accept and emit with a full pipe is legal and loses no beat.
- Reset mid-operation discards all in-flight beats; no partial result is emitted.
- Inputs are ignored when in_valid = 0 (X on a/b is harmless).

Optional Feature:
CLA_SAT_EN: adds input port sat (1 bit, sampled with the beat).
- With the macro, when sat = 1 and ovf = 1, r clamps to 0x7F..F if the true result is positive (both effective operands non-negative) and to 0x80..0 if negative. ovf and cout still report the unclamped condition, and zero reflects the clamped r.
- Without the macro, the port is absent and r always wraps modulo 2^WIDTH.

Test Plan:
WIDTH=16, STAGES=2: a=0x7FFF, b=0x0001, sub=0, cin=0 -> after 2 cycles r=0x8000, ovf=1, cout=0, zero=0.
a=0x0005, b=0x0007, sub=1, cin=0 -> r=0xFFFE, cout=0, ovf=0; same with cin=1 -> r=0xFFFD.
a=0xFFFF, b=0x0001, add -> r=0x0000, cout=1, zero=1, ovf=0; randomised 10k beats match a reference model for STAGES=1,2,4.
Stream 6 beats back-to-back, out_ready low for cycles 2-5 -> in_ready drops after 2 beats are held, all 6 results emerge in order, none lost.
Assert reset with 2 beats in flight -> out_valid=0 next cycle, outputs 0, no stale beat emitted after release.
CLA_SAT_EN, sat=1: 0x7FFF+0x0001 -> r=0x7FFF, ovf=1; 0x8000-0x0001 -> r=0x8000, ovf=1; sat=0 -> r wraps to 0x8000 and 0x7FFF.
